// File: rtl/clk_pkg.sv
// Shared definitions for the capture-side byte packer.
//   DW_DEFAULT      : default byte width, matches the upstream dout bus
//   pack_state_t    : pack FSM states (ST_EMPTY / ST_FILL)
//   clog2_f         : ceil(log2(v)) usable in parameter expressions
package clk_pkg;

    localparam int DW_DEFAULT = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FILL  = 1'b1
    } pack_state_t;

    // Bounded loop so it elaborates as a constant function.
    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ddr_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst : clock, synchronous active-high reset
//   push     : write wdata (ignored when full unless a pop happens the same cycle)
//   pop      : consume the head entry (ignored when empty)
//   rdata    : head entry; forced to 0 while empty
//   empty    : no entry held
//   full     : DEPTH entries held
//   level    : occupancy, extra MSB separates full from empty
module ddr_sync_fifo
    import clk_pkg::*;
#(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4,
    localparam int AW   = clog2_f(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);

    // Storage is not reset; the output mux hides stale entries.
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ddr_word_packer.sv
// Packs the upstream byte stream into WORD_BYTES-wide words and queues them
// for a valid/ready master port. Partial words close on flush or idle timeout.
//   clk, rst         : clock, synchronous active-high reset
//   din, din_en      : incoming byte and its strobe (no backpressure)
//   flush            : close the current partial word
//   m_data/keep/last : head word, byte-valid mask, closed-by-flush/timeout
//   m_valid, m_ready : output handshake
//   level            : FIFO occupancy
//   overflow         : sticky, a completed word was dropped on a full FIFO
module ddr_word_packer
    import clk_pkg::*;
#(
    parameter int DW         = DW_DEFAULT,
    parameter int WORD_BYTES = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int IDLE_TO    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DW-1:0]              din,
    input  logic                       din_en,
    input  logic                       flush,
    output logic [DW*WORD_BYTES-1:0]   m_data,
    output logic [WORD_BYTES-1:0]      m_keep,
    output logic                       m_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [clog2_f(FIFO_DEPTH):0] level,
    output logic                       overflow
);

    localparam int BW = clog2_f(WORD_BYTES);
    localparam int CW = BW + 1;
    localparam int TW = (IDLE_TO > 0) ? clog2_f(IDLE_TO + 1) : 1;
    localparam int FW = DW*WORD_BYTES + WORD_BYTES + 1;

    pack_state_t                         state, state_d;
    logic [CW-1:0]                       cnt, cnt_d, cnt_inc;
    logic [TW-1:0]                       idle_cnt, idle_d;
    logic [WORD_BYTES-1:0][DW-1:0]       word_q, word_ins, word_d;
    logic [WORD_BYTES-1:0]               keep_w;
    logic                                timeout, close, push, push_last;
    logic                                fifo_empty, fifo_full;
    logic [FW-1:0]                       fifo_rdata;

    // Fires on the IDLE_TO-th consecutive idle cycle while a partial word is held.
    assign timeout = (IDLE_TO != 0) && (state == ST_FILL) && !din_en &&
                     (idle_cnt == TW'(IDLE_TO - 1));

    // Byte k is valid when the (post-insert) count covers it.
    for (genvar k = 0; k < WORD_BYTES; k++) begin : g_keep
        assign keep_w[k] = (CW'(k) < cnt_inc);
    end

    always_comb begin
        word_ins  = word_q;
        cnt_inc   = cnt;
        if (din_en) begin
            word_ins[cnt[BW-1:0]] = din;
            cnt_inc               = cnt + 1'b1;
        end

        // The arriving byte is always included before the word is closed.
        close     = (cnt_inc == CW'(WORD_BYTES)) ||
                    ((flush || timeout) && (cnt_inc != '0));
        push      = close;
        push_last = flush || timeout;

        if (close) begin
            word_d  = '0;
            cnt_d   = '0;
            state_d = ST_EMPTY;
            idle_d  = '0;
        end else begin
            word_d  = word_ins;
            cnt_d   = cnt_inc;
            state_d = (cnt_inc != '0) ? ST_FILL : ST_EMPTY;
            idle_d  = (din_en || state != ST_FILL) ? '0 : idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            cnt      <= '0;
            idle_cnt <= '0;
            word_q   <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            idle_cnt <= idle_d;
            word_q   <= word_d;
        end
    end

    // With a full FIFO the only slot that can free up is via m_ready.
    always_ff @(posedge clk) begin
        if (rst)                               overflow <= 1'b0;
        else if (push && fifo_full && !m_ready) overflow <= 1'b1;
    end

    ddr_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({push_last, keep_w, word_ins}),
        .pop   (m_ready),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

    assign m_valid = ~fifo_empty;
    assign {m_last, m_keep, m_data} = fifo_rdata;

endmodule

// File: tb/tb_ddr_word_packer.sv
module tb_ddr_word_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        din_en;
    logic        flush;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;
    logic [2:0]  level;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    bit started = 0;

    always #5 clk = ~clk;

    ddr_word_packer #(.DW(8), .WORD_BYTES(4), .FIFO_DEPTH(4), .IDLE_TO(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_en   (din_en),
        .flush    (flush),
        .m_data   (m_data),
        .m_keep   (m_keep),
        .m_last   (m_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .level    (level),
        .overflow (overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending bytes and a list of queued words.
    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    word_t mq[$];
    logic [7:0] mb[$];
    int  midle = 0;
    bit  movf  = 0;

    always @(posedge clk) begin
        bit    pop, cl, lst;
        word_t w;
        if (rst) begin
            mq.delete(); mb.delete(); midle = 0; movf = 0;
        end else begin
            pop = (mq.size() > 0) && m_ready;
            if (din_en) begin
                mb.push_back(din);
                midle = 0;
            end else if (mb.size() > 0) begin
                midle++;
            end
            lst = (flush || midle == 16) && (mb.size() > 0);
            cl  = (mb.size() == 4) || lst;
            if (cl) begin
                w.data = 32'h0;
                for (int i = 0; i < mb.size(); i++) w.data[8*i +: 8] = mb[i];
                w.keep = 4'((1 << mb.size()) - 1);
                w.last = lst;
                mb.delete();
                midle = 0;
            end
            if (pop) void'(mq.pop_front());
            if (cl) begin
                if (mq.size() < 4) mq.push_back(w);
                else               movf = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_valid",  m_valid,  mq.size() > 0);
            chk("m_data",   m_data,   mq.size() > 0 ? mq[0].data : 32'h0);
            chk("m_keep",   m_keep,   mq.size() > 0 ? mq[0].keep : 4'h0);
            chk("m_last",   m_last,   mq.size() > 0 ? mq[0].last : 1'b0);
            chk("level",    level,    mq.size());
            chk("overflow", overflow, movf);
        end
    end

    task automatic step(input bit e, input logic [7:0] d, input bit f);
        din_en = e; din = d; flush = f;
        @(posedge clk);
        @(negedge clk);
        din_en = 0; flush = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        step(0, 0, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data",  m_data, 0);
        chk("rst_keep",  m_keep, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf",   overflow, 0);
        rst = 0;
    endtask

    initial begin
        rst = 1; din = 0; din_en = 0; flush = 0; m_ready = 0;
        @(posedge clk);
        started = 1;
        @(negedge clk);
        do_reset();

        // 1: two full words back-to-back, valid one cycle after 4th byte
        m_ready = 1;
        for (int i = 0; i < 4; i++) step(1, 8'(8'h11 * (i + 1)), 0);
        chk("t1_w0_valid", m_valid, 1);
        chk("t1_w0_data",  m_data, 32'h44332211);
        chk("t1_w0_keep",  m_keep, 4'hF);
        chk("t1_w0_last",  m_last, 0);
        for (int i = 4; i < 8; i++) step(1, 8'(8'h11 * (i + 1)), 0);
        chk("t1_w1_data",  m_data, 32'h88776655);
        step(0, 0, 0);

        // 2: partial word on flush, flush in EMPTY is a no-op
        m_ready = 0;
        step(1, 8'hA1, 0); step(1, 8'hA2, 0); step(1, 8'hA3, 0);
        step(0, 0, 1);
        chk("t2_data", m_data, 32'h00A3A2A1);
        chk("t2_keep", m_keep, 4'h7);
        chk("t2_last", m_last, 1);
        m_ready = 1; step(0, 0, 0); m_ready = 0;
        step(0, 0, 1);
        chk("t2_empty_flush", m_valid, 0);

        // 3: idle timeout after 16 idle cycles
        step(1, 8'hC1, 0); step(1, 8'hC2, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 0);
        chk("t3_no_early", m_valid, 0);
        step(0, 0, 0);
        chk("t3_to_valid", m_valid, 1);
        chk("t3_to_data",  m_data, 32'h0000C2C1);
        chk("t3_to_keep",  m_keep, 4'h3);
        chk("t3_to_last",  m_last, 1);
        m_ready = 1; step(0, 0, 0); m_ready = 0;
        step(1, 8'hD1, 0); step(1, 8'hD2, 0);
        for (int i = 0; i < 14; i++) step(0, 0, 0);
        step(1, 8'hD3, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 0);
        chk("t3_restart", m_valid, 0);
        step(0, 0, 0);
        chk("t3_restart_keep", m_keep, 4'h7);
        m_ready = 1; step(0, 0, 0); m_ready = 0;

        // 4: overflow on the 5th word, drain keeps order, overflow sticky
        for (int i = 0; i < 20; i++) step(1, 8'(i + 1), 0);
        chk("t4_level", level, 4);
        chk("t4_ovf",   overflow, 1);
        m_ready = 1;
        for (int j = 0; j < 4; j++) begin
            chk("t4_drain", m_data,
                {8'(4*j + 4), 8'(4*j + 3), 8'(4*j + 2), 8'(4*j + 1)});
            step(0, 0, 0);
        end
        chk("t4_drained", m_valid, 0);
        chk("t4_ovf_sticky", overflow, 1);
        m_ready = 0;

        // 5: 4th byte with flush; push+pop on a full FIFO
        do_reset();
        step(1, 8'hB0, 0); step(1, 8'hB1, 0); step(1, 8'hB2, 0);
        step(1, 8'hB3, 1);
        chk("t5_data", m_data, 32'hB3B2B1B0);
        chk("t5_keep", m_keep, 4'hF);
        chk("t5_last", m_last, 1);
        for (int i = 0; i < 15; i++) step(1, 8'(8'h40 + i), 0);
        chk("t5_full", level, 4);
        m_ready = 1;
        step(1, 8'h4F, 0);
        m_ready = 0;
        chk("t5_level", level, 4);
        chk("t5_no_ovf", overflow, 0);
        chk("t5_head", m_data, 32'h43424140);

        // 6: reset mid-word discards everything
        do_reset();
        step(1, 8'hEE, 0); step(1, 8'hEF, 0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 8'(i + 1), 0);
        chk("t6_level", level, 1);
        chk("t6_data", m_data, 32'h04030201);
        chk("t6_keep", m_keep, 4'hF);
        m_ready = 1; step(0, 0, 0);

        // Random traffic against the model
        for (int n = 0; n < 2000; n++) begin
            m_ready = ($urandom_range(0, 99) < 60);
            rst     = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 99) < 3) begin
                for (int g = 0; g < int'($urandom_range(10, 20)); g++) step(0, 0, 0);
            end else begin
                step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 4);
            end
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
